// File: rtl/ioctl_loader.sv
// Packs ioctl download beats into SDRAM words and writes them through a toggle req/ack port.
// Each channel maps an ioctl index to its own SDRAM base address and size window.
module ioctl_loader #(
    parameter int IOCTL_DW = 16,
    parameter int SDRAM_DW = 32,
    parameter int AW       = 25,
    parameter int NCH      = 2,
    parameter logic [NCH*6-1:0]  CH_IDX  = {6'h02, 6'h00},
    parameter logic [NCH*AW-1:0] CH_BASE = {25'h0800000, 25'h0},
    parameter logic [NCH*AW-1:0] CH_SIZE = {25'h0800000, 25'h0800000}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ioctl_download,
    input  logic [7:0]            ioctl_index,
    input  logic                  ioctl_wr,
    input  logic [IOCTL_DW-1:0]   ioctl_dout,
    output logic                  ioctl_wait,
    output logic [AW-1:0]         sdram_waddr,
    output logic [SDRAM_DW-1:0]   sdram_din,
    output logic [SDRAM_DW/8-1:0] sdram_be,
    output logic                  sdram_we_req,
    input  logic                  sdram_we_ack,
    output logic                  active,
    output logic [1:0]            ch,
    output logic                  done,
    output logic                  ovf
);
    localparam int R    = SDRAM_DW / IOCTL_DW;
    localparam int LW   = (R > 1) ? $clog2(R) : 1;
    localparam int BPB  = IOCTL_DW / 8;
    localparam logic [LW-1:0] LAST = LW'(R - 1);
    localparam logic [AW-1:0] STEP = AW'(SDRAM_DW / 8);

    typedef enum logic [2:0] {StIdle, StFill, StFlush, StWrite, StDone} state_e;

    state_e          state_q;
    logic            dl_q;
    logic            rise_pend_q;
    logic            fall_pend_q;
    logic            flush_q;
    logic [LW-1:0]   lane_q;
    logic [AW-1:0]   ofs_q;
    logic            hit;
    logic [1:0]      hit_ch;
    logic [AW-1:0]   hit_base;
    logic [AW-1:0]   cur_size;
    logic            dl_rise;
    logic            dl_fall;
    logic            in_window;
    logic            unused_index;

    assign unused_index = ^ioctl_index[7:6];
    assign dl_rise      = ioctl_download & ~dl_q;
    assign dl_fall      = ~ioctl_download & dl_q;
    assign in_window    = ofs_q < cur_size;

    // Descending scan so the lowest matching channel wins.
    always_comb begin
        hit      = 1'b0;
        hit_ch   = '0;
        hit_base = '0;
        cur_size = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ioctl_index[5:0] == CH_IDX[i*6 +: 6]) begin
                hit      = 1'b1;
                hit_ch   = 2'(i);
                hit_base = CH_BASE[i*AW +: AW];
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (ch == 2'(i)) cur_size = CH_SIZE[i*AW +: AW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            dl_q         <= 1'b0;
            rise_pend_q  <= 1'b0;
            fall_pend_q  <= 1'b0;
            flush_q      <= 1'b0;
            lane_q       <= '0;
            ofs_q        <= '0;
            ioctl_wait   <= 1'b0;
            sdram_waddr  <= '0;
            sdram_din    <= '0;
            sdram_be     <= '0;
            sdram_we_req <= 1'b0;
            active       <= 1'b0;
            ch           <= '0;
            done         <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            done <= 1'b0;
            // Edges seen outside IDLE are remembered and acted on later.
            if (dl_rise && state_q != StIdle) rise_pend_q <= 1'b1;
            if (dl_fall && state_q == StWrite) fall_pend_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    rise_pend_q <= 1'b0;
                    if ((dl_rise || rise_pend_q) && ioctl_download && hit) begin
                        ch          <= hit_ch;
                        sdram_waddr <= hit_base;
                        ofs_q       <= '0;
                        sdram_be    <= '0;
                        lane_q      <= '0;
                        fall_pend_q <= 1'b0;
                        active      <= 1'b1;
                        state_q     <= StFill;
                    end
                end
                StFill: begin
                    if (ioctl_wr) begin
                        sdram_din[lane_q*IOCTL_DW +: IOCTL_DW] <= ioctl_dout;
                        sdram_be[lane_q*BPB +: BPB]            <= '1;
                        if (lane_q == LAST) begin
                            if (in_window) begin
                                sdram_we_req <= ~sdram_we_req;
                                ioctl_wait   <= 1'b1;
                                flush_q      <= 1'b0;
                                state_q      <= StWrite;
                            end else begin
                                ovf         <= 1'b1;
                                lane_q      <= '0;
                                sdram_be    <= '0;
                                ofs_q       <= ofs_q + STEP;
                                sdram_waddr <= sdram_waddr + STEP;
                            end
                        end else begin
                            lane_q <= lane_q + LW'(1);
                        end
                    end else if (!ioctl_download) begin
                        if (lane_q != '0) begin
                            state_q <= StFlush;
                        end else begin
                            done    <= 1'b1;
                            active  <= 1'b0;
                            state_q <= StDone;
                        end
                    end
                end
                StFlush: begin
                    if (in_window) begin
                        sdram_we_req <= ~sdram_we_req;
                        ioctl_wait   <= 1'b1;
                        flush_q      <= 1'b1;
                        state_q      <= StWrite;
                    end else begin
                        ovf     <= 1'b1;
                        done    <= 1'b1;
                        active  <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StWrite: begin
                    if (sdram_we_req == sdram_we_ack) begin
                        ioctl_wait  <= 1'b0;
                        sdram_waddr <= sdram_waddr + STEP;
                        ofs_q       <= ofs_q + STEP;
                        lane_q      <= '0;
                        sdram_be    <= '0;
                        fall_pend_q <= 1'b0;
                        if (flush_q || fall_pend_q || !ioctl_download) begin
                            done    <= 1'b1;
                            active  <= 1'b0;
                            state_q <= StDone;
                        end else begin
                            state_q <= StFill;
                        end
                    end
                end
                StDone: begin
                    ovf     <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
